// File: rtl/i2s_stream_sched.sv
// Per-frame scheduler: mic sample hand-off plus one committed speaker sample per LRCLK frame.
// Optional macro I2S_SCHED_HOLD_EN: repeat the last committed sample on underrun instead of silence.
module i2s_stream_sched #(
  parameter int C_DATA_WIDTH = 24,
  parameter int C_DEADLINE   = 200
) (
  input  logic                    CLK_12,
  input  logic                    resetn,
  input  logic                    LRCLK_I,
  input  logic [C_DATA_WIDTH-1:0] mic_sample,
  output logic [C_DATA_WIDTH-1:0] mic_data,
  output logic                    mic_valid,
  input  logic                    mic_ready,
  input  logic [C_DATA_WIDTH-1:0] src0_data,
  input  logic                    src0_valid,
  output logic                    src0_ready,
  input  logic [C_DATA_WIDTH-1:0] src1_data,
  input  logic                    src1_valid,
  output logic                    src1_ready,
  input  logic [1:0]              mode,
  output logic [C_DATA_WIDTH-1:0] spk_sample,
  output logic                    spk_update,
  output logic                    underrun,
  output logic                    overrun,
  output logic                    sched_err,
  input  logic                    clr_err
);
  localparam int W = C_DATA_WIDTH;
  localparam logic [7:0] LAST_CNT = 8'(C_DEADLINE - 1);
  localparam logic signed [W:0] SAT_MAX = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0] SAT_MIN = {2'b11, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, COMMIT = 2'd2} state_t;

  state_t            state;
  logic              lrclk_q;
  logic              frame_evt;
  logic              pending;
  logic              got0;
  logic              got1;
  logic [1:0]        mode_q;
  logic [7:0]        cnt;
  logic [W-1:0]      s0_q;
  logic [W-1:0]      s1_q;
  logic [W-1:0]      conceal;
  logic [W-1:0]      commit_val;
  logic              commit_ur;
  logic              req0;
  logic              req1;
  logic              all_got;
  logic signed [W:0] sum;

  assign frame_evt  = LRCLK_I && !lrclk_q;
  assign req0       = (mode_q == 2'd0) || (mode_q == 2'd2);
  assign req1       = (mode_q == 2'd1) || (mode_q == 2'd2);
  assign src0_ready = (state == COLLECT) && req0 && !got0;
  assign src1_ready = (state == COLLECT) && req1 && !got1;
  assign all_got    = (got0 || !req0) && (got1 || !req1);
  assign sum        = $signed({s0_q[W-1], s0_q}) + $signed({s1_q[W-1], s1_q});

  // Value and underrun flag presented while in COMMIT
  always_comb begin
    commit_val = '0;
    commit_ur  = 1'b0;
    case (mode_q)
      2'd0: begin
        if (got0) begin
          commit_val = s0_q;
        end else begin
          commit_val = conceal;
          commit_ur  = 1'b1;
        end
      end
      2'd1: begin
        if (got1) begin
          commit_val = s1_q;
        end else begin
          commit_val = conceal;
          commit_ur  = 1'b1;
        end
      end
      2'd2: begin
        if (got0 && got1) begin
          if (sum > SAT_MAX) begin
            commit_val = SAT_MAX[W-1:0];
          end else if (sum < SAT_MIN) begin
            commit_val = SAT_MIN[W-1:0];
          end else begin
            commit_val = sum[W-1:0];
          end
        end else begin
          commit_val = conceal;
          commit_ur  = 1'b1;
        end
      end
      default: begin
        commit_val = '0;
        commit_ur  = 1'b0;
      end
    endcase
  end

`ifdef I2S_SCHED_HOLD_EN
  logic [W-1:0] hold_q;

  // Sample-and-hold copy of the last committed speaker value
  always_ff @(posedge CLK_12 or posedge resetn) begin
    if (resetn) begin
      hold_q <= '0;
    end else if (state == COMMIT) begin
      hold_q <= commit_val;
    end
  end
  assign conceal = hold_q;
`else
  assign conceal = '0;
`endif

  // Mic path: capture on every frame event, independent of the playback FSM
  always_ff @(posedge CLK_12 or posedge resetn) begin
    if (resetn) begin
      lrclk_q   <= 1'b0;
      mic_data  <= '0;
      mic_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      lrclk_q <= LRCLK_I;
      overrun <= frame_evt && mic_valid && !mic_ready;
      if (frame_evt) begin
        mic_data  <= mic_sample;
        mic_valid <= 1'b1;
      end else if (mic_ready) begin
        mic_valid <= 1'b0;
      end
    end
  end

  // Playback FSM; a frame event outside IDLE forces an early commit and queues a restart
  always_ff @(posedge CLK_12 or posedge resetn) begin
    if (resetn) begin
      state      <= IDLE;
      mode_q     <= 2'd0;
      got0       <= 1'b0;
      got1       <= 1'b0;
      cnt        <= 8'd0;
      pending    <= 1'b0;
      s0_q       <= '0;
      s1_q       <= '0;
      spk_sample <= '0;
      spk_update <= 1'b0;
      underrun   <= 1'b0;
      sched_err  <= 1'b0;
    end else begin
      spk_update <= 1'b0;
      underrun   <= 1'b0;
      if (frame_evt && (state != IDLE)) begin
        sched_err <= 1'b1;
        pending   <= 1'b1;
      end else if (clr_err) begin
        sched_err <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (frame_evt || pending) begin
            mode_q  <= mode;
            got0    <= 1'b0;
            got1    <= 1'b0;
            cnt     <= 8'd0;
            pending <= 1'b0;
            state   <= (mode == 2'd3) ? COMMIT : COLLECT;
          end
        end
        COLLECT: begin
          cnt <= cnt + 8'd1;
          if (src0_valid && src0_ready) begin
            s0_q <= src0_data;
            got0 <= 1'b1;
          end
          if (src1_valid && src1_ready) begin
            s1_q <= src1_data;
            got1 <= 1'b1;
          end
          if (frame_evt || all_got || (cnt == LAST_CNT)) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          spk_sample <= commit_val;
          spk_update <= 1'b1;
          underrun   <= commit_ur;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2s_stream_sched.sv
// Self-checking bench for i2s_stream_sched: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_i2s_stream_sched;
  localparam int W     = 24;
  localparam int DL    = 200;
  localparam int NEVER = 1000;

  logic         CLK_12 = 1'b0;
  logic         resetn, LRCLK_I, mic_valid, mic_ready;
  logic [W-1:0] mic_sample, mic_data, src0_data, src1_data, spk_sample;
  logic         src0_valid, src0_ready, src1_valid, src1_ready;
  logic [1:0]   mode;
  logic         spk_update, underrun, overrun, sched_err, clr_err;

  int           vectors = 0;
  int           errors  = 0;
  logic [W-1:0] model_spk;
  bit           model_mic_pend;

  i2s_stream_sched #(.C_DATA_WIDTH(W), .C_DEADLINE(DL)) dut (
    .CLK_12(CLK_12), .resetn(resetn), .LRCLK_I(LRCLK_I),
    .mic_sample(mic_sample), .mic_data(mic_data), .mic_valid(mic_valid), .mic_ready(mic_ready),
    .src0_data(src0_data), .src0_valid(src0_valid), .src0_ready(src0_ready),
    .src1_data(src1_data), .src1_valid(src1_valid), .src1_ready(src1_ready),
    .mode(mode), .spk_sample(spk_sample), .spk_update(spk_update), .underrun(underrun),
    .overrun(overrun), .sched_err(sched_err), .clr_err(clr_err)
  );

  always #5 CLK_12 = ~CLK_12;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK_12);
    #1;
  endtask

  function automatic logic [W-1:0] conceal_val();
`ifdef I2S_SCHED_HOLD_EN
    return model_spk;
`else
    return '0;
`endif
  endfunction

  // Frame-level model of the committed value
  function automatic logic [W-1:0] ref_commit(input logic [1:0] m, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input bit have0,
                                              input bit have1, output bit ur);
    int sa, sb, s;
    ur = 1'b0;
    if (m == 2'd3) return '0;
    if ((m != 2'd1 && !have0) || (m != 2'd0 && !have1)) begin
      ur = 1'b1;
      return conceal_val();
    end
    if (m == 2'd0) return a;
    if (m == 2'd1) return b;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = sa + sb;
    if (s > 8388607) s = 8388607;
    if (s < -8388608) s = -8388608;
    return W'(s);
  endfunction

  // Cycles from frame event to spk_update
  function automatic int ref_latency(input logic [1:0] m, input int d0, input int d1);
    bit n0, n1;
    int last;
    if (m == 2'd3) return 2;
    n0 = (m == 2'd0) || (m == 2'd2);
    n1 = (m == 2'd1) || (m == 2'd2);
    if ((n0 && d0 > DL) || (n1 && d1 > DL)) return DL + 2;
    last = 0;
    if (n0) last = (d0 < 1) ? 1 : d0;
    if (n1 && ((d1 < 1) ? 1 : d1) > last) last = (d1 < 1) ? 1 : d1;
    return last + 3;
  endfunction

  function automatic logic [W-1:0] pick_data();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 24'h7FFFFF;
    if (r == 1) return 24'h800000;
    if (r == 2) return 24'h400001;
    return W'($urandom);
  endfunction

  task automatic test_reset();
    resetn = 1'b1; LRCLK_I = 1'b0; mic_ready = 1'b1; mic_sample = '0;
    src0_data = '0; src1_data = '0; src0_valid = 1'b0; src1_valid = 1'b0;
    mode = 2'd0; clr_err = 1'b0;
    tick(); tick();
    vectors++;
    if ({mic_data, mic_valid, src0_ready, src1_ready, spk_sample, spk_update, underrun,
         overrun, sched_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got mic_data=%h mic_valid=%b spk=%h upd=%b ur=%b ov=%b err=%b required all 0",
               mic_data, mic_valid, spk_sample, spk_update, underrun, overrun, sched_err);
    end
    resetn = 1'b0;
    tick();
    model_spk = '0;
    model_mic_pend = 1'b0;
  endtask

  task automatic test_mode0();
    int lat = -1;
    logic [W-1:0] v = '0;
    bit u = 1'b0, saw1 = 1'b0, rdy5 = 1'b0, rdy6 = 1'b1;
    mode = 2'd0; src0_data = 24'h123456; src1_data = W'($urandom);
    src0_valid = 1'b0; src1_valid = 1'b1; mic_ready = 1'b1; mic_sample = W'($urandom);
    LRCLK_I = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 2) LRCLK_I = 1'b0;
      if (src1_ready) saw1 = 1'b1;
      if (k == 5) begin rdy5 = src0_ready; src0_valid = 1'b1; end
      if (k == 6) begin rdy6 = src0_ready; src0_valid = 1'b0; end
      if (spk_update && lat < 0) begin lat = k; v = spk_sample; u = underrun; end
    end
    src1_valid = 1'b0;
    vectors += 6;
    if (lat !== 8) begin errors++; $display("FAIL mode0_latency: got %0d required 8", lat); end
    if (v !== 24'h123456) begin errors++; $display("FAIL mode0_value: got %h required 123456", v); end
    if (u !== 1'b0) begin errors++; $display("FAIL mode0_underrun: got %b required 0", u); end
    if (saw1 !== 1'b0) begin errors++; $display("FAIL mode0_src1_ready: got asserted required never"); end
    if (rdy5 !== 1'b1) begin errors++; $display("FAIL mode0_src0_ready_before: got %b required 1", rdy5); end
    if (rdy6 !== 1'b0) begin errors++; $display("FAIL mode0_src0_ready_after: got %b required 0", rdy6); end
    model_spk = 24'h123456;
    model_mic_pend = 1'b0;
  endtask

  task automatic test_mix_sat();
    int lat = -1;
    logic [W-1:0] v = '0;
    bit u = 1'b1;
    mode = 2'd2; src0_data = 24'h7FFFF0; src1_data = 24'h000100;
    src0_valid = 1'b1; src1_valid = 1'b1; LRCLK_I = 1'b1; mic_sample = W'($urandom);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 2) LRCLK_I = 1'b0;
      if (spk_update && lat < 0) begin lat = k; v = spk_sample; u = underrun; end
    end
    src0_valid = 1'b0; src1_valid = 1'b0;
    vectors += 3;
    if (lat !== 4) begin errors++; $display("FAIL mix_latency: got %0d required 4", lat); end
    if (v !== 24'h7FFFFF) begin errors++; $display("FAIL mix_saturate: got %h required 7fffff", v); end
    if (u !== 1'b0) begin errors++; $display("FAIL mix_underrun: got %b required 0", u); end
    model_spk = 24'h7FFFFF;
  endtask

  task automatic test_deadline();
    int lat = -1;
    logic [W-1:0] v = '0, exp_v;
    bit u = 1'b0;
    exp_v = conceal_val();
    mode = 2'd1; src1_valid = 1'b0; src0_valid = 1'b1; src0_data = W'($urandom);
    LRCLK_I = 1'b1; mic_sample = W'($urandom);
    for (int k = 1; k <= DL + 5; k++) begin
      tick();
      if (k == 2) LRCLK_I = 1'b0;
      if (spk_update && lat < 0) begin lat = k; v = spk_sample; u = underrun; end
    end
    src0_valid = 1'b0;
    vectors += 3;
    if (lat !== DL + 2) begin errors++; $display("FAIL deadline_latency: got %0d required %0d", lat, DL + 2); end
    if (u !== 1'b1) begin errors++; $display("FAIL deadline_underrun: got %b required 1", u); end
    if (v !== exp_v) begin errors++; $display("FAIL deadline_value: got %h required %h", v, exp_v); end
    model_spk = exp_v;
  endtask

  task automatic test_overrun();
    mode = 2'd3; mic_ready = 1'b0; mic_sample = 24'h000AAA; LRCLK_I = 1'b1;
    tick();
    vectors += 2;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_first: got %b required 0", overrun); end
    if (mic_data !== 24'h000AAA) begin errors++; $display("FAIL overrun_data_a: got %h required 000aaa", mic_data); end
    LRCLK_I = 1'b0;
    tick(); tick(); tick();
    mic_sample = 24'h000BBB; LRCLK_I = 1'b1;
    tick();
    vectors += 3;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_second: got %b required 1", overrun); end
    if (mic_data !== 24'h000BBB) begin errors++; $display("FAIL overrun_data_b: got %h required 000bbb", mic_data); end
    if (mic_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b required 1", mic_valid); end
    LRCLK_I = 1'b0;
    tick();
    vectors += 2;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_pulse_width: got %b required 0", overrun); end
    if (mic_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid_held: got %b required 1", mic_valid); end
    tick(); tick();
    mic_ready = 1'b1;
    tick();
    vectors++;
    if (mic_valid !== 1'b0) begin errors++; $display("FAIL mic_handshake: got valid %b required 0", mic_valid); end
    model_spk = '0;
    model_mic_pend = 1'b0;
  endtask

  task automatic test_sched_err();
    int n = 0;
    int t[2];
    logic [W-1:0] v[2];
    bit u[2];
    bit err_seen = 1'b0, kept = 1'b0;
    logic [W-1:0] d, e, exp_c;
    d = W'($urandom); e = W'($urandom); exp_c = conceal_val();
    t[0] = -1; t[1] = -1; v[0] = '0; v[1] = '0; u[0] = 1'b0; u[1] = 1'b1;
    mode = 2'd0; src0_valid = 1'b0; src0_data = d; mic_ready = 1'b1; LRCLK_I = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 2) LRCLK_I = 1'b0;
      if (k == 9) LRCLK_I = 1'b1;
      if (k == 10) err_seen = sched_err;
      if (k == 11) begin LRCLK_I = 1'b0; src0_valid = 1'b1; end
      if (k == 16) src0_valid = 1'b0;
      if (spk_update && n < 2) begin t[n] = k; v[n] = spk_sample; u[n] = underrun; n++; end
    end
    vectors += 7;
    if (err_seen !== 1'b1) begin errors++; $display("FAIL sched_err_set: got %b required 1", err_seen); end
    if (t[0] !== 11) begin errors++; $display("FAIL forced_commit_time: got %0d required 11", t[0]); end
    if (u[0] !== 1'b1) begin errors++; $display("FAIL forced_commit_underrun: got %b required 1", u[0]); end
    if (v[0] !== exp_c) begin errors++; $display("FAIL forced_commit_value: got %h required %h", v[0], exp_c); end
    if (t[1] !== 15) begin errors++; $display("FAIL restart_commit_time: got %0d required 15", t[1]); end
    if (u[1] !== 1'b0) begin errors++; $display("FAIL restart_underrun: got %b required 0", u[1]); end
    if (v[1] !== d) begin errors++; $display("FAIL restart_value: got %h required %h", v[1], d); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    vectors++;
    if (sched_err !== 1'b0) begin errors++; $display("FAIL clr_err: got %b required 0", sched_err); end
    src0_data = e; LRCLK_I = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 2) LRCLK_I = 1'b0;
      if (k == 5) begin LRCLK_I = 1'b1; clr_err = 1'b1; end
      if (k == 6) begin kept = sched_err; clr_err = 1'b0; LRCLK_I = 1'b0; end
      if (k == 7) src0_valid = 1'b1;
      if (k == 12) src0_valid = 1'b0;
    end
    vectors += 2;
    if (kept !== 1'b1) begin errors++; $display("FAIL set_beats_clear: got %b required 1", kept); end
    if (spk_sample !== e) begin errors++; $display("FAIL set_wins_restart_value: got %h required %h", spk_sample, e); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    model_spk = e;
    model_mic_pend = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic r_before;
    mode = 2'd2; src0_data = W'($urandom) | 24'h1; src1_valid = 1'b0; src0_valid = 1'b0;
    mic_ready = 1'b0; mic_sample = W'($urandom) | 24'h1; LRCLK_I = 1'b1;
    tick();
    src0_valid = 1'b1;
    tick();
    LRCLK_I = 1'b0;
    tick();
    r_before = src0_ready;
    resetn = 1'b1;
    #1;
    vectors += 2;
    if (r_before !== 1'b0) begin errors++; $display("FAIL mid_got0_ready: got %b required 0", r_before); end
    if ({mic_data, mic_valid, src0_ready, src1_ready, spk_sample, spk_update, underrun,
         overrun, sched_err} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got mic_valid=%b spk=%h src1_ready=%b err=%b required all 0",
               mic_valid, spk_sample, src1_ready, sched_err);
    end
    tick(); tick();
    src0_valid = 1'b0; mic_ready = 1'b1; resetn = 1'b0;
    tick();
    model_spk = '0;
    model_mic_pend = 1'b0;
    test_mode0();
  endtask

  task automatic test_random();
    logic [1:0] m;
    logic [W-1:0] a, b, mic, exp_v;
    int d0, d1, lat;
    bit rdy, have0, have1, exp_u, exp_ov;
    for (int f = 0; f < 40; f++) begin
      m = 2'($urandom_range(0, 3));
      a = pick_data(); b = pick_data(); mic = W'($urandom);
      d0 = ($urandom_range(0, 6) == 0) ? NEVER : $urandom_range(0, 12);
      d1 = ($urandom_range(0, 6) == 0) ? NEVER : $urandom_range(0, 12);
      rdy = 1'($urandom_range(0, 1));
      have0 = ((m == 2'd0) || (m == 2'd2)) && (d0 <= DL);
      have1 = ((m == 2'd1) || (m == 2'd2)) && (d1 <= DL);
      exp_v  = ref_commit(m, a, b, have0, have1, exp_u);
      lat    = ref_latency(m, d0, d1);
      exp_ov = model_mic_pend && !rdy;
      mode = m; src0_data = a; src1_data = b; mic_sample = mic; mic_ready = rdy;
      src0_valid = (d0 == 0); src1_valid = (d1 == 0); LRCLK_I = 1'b1;
      for (int k = 1; k <= lat + 1; k++) begin
        tick();
        if (k == 2) LRCLK_I = 1'b0;
        if (k == 3) mode = 2'($urandom_range(0, 3));
        if (k == d0) src0_valid = 1'b1;
        if (k == d1) src1_valid = 1'b1;
        if (k == 1) begin
          vectors++;
          if ({mic_data, mic_valid, overrun} !== {mic, 1'b1, exp_ov}) begin
            errors++;
            $display("FAIL rand_mic f%0d: got data=%h valid=%b ov=%b required data=%h valid=1 ov=%b",
                     f, mic_data, mic_valid, overrun, mic, exp_ov);
          end
        end
        vectors++;
        if ({spk_update, underrun} !== {(k == lat), (k == lat) && exp_u}) begin
          errors++;
          $display("FAIL rand_pulses f%0d k%0d mode%0d: got upd=%b ur=%b required upd=%b ur=%b",
                   f, k, m, spk_update, underrun, (k == lat), (k == lat) && exp_u);
        end
        if (k == lat) begin
          vectors++;
          if (spk_sample !== exp_v) begin
            errors++;
            $display("FAIL rand_value f%0d mode%0d: got %h required %h", f, m, spk_sample, exp_v);
          end
        end
      end
      vectors++;
      if (mic_valid !== !rdy) begin
        errors++;
        $display("FAIL rand_mic_valid_end f%0d: got %b required %b", f, mic_valid, !rdy);
      end
      src0_valid = 1'b0; src1_valid = 1'b0;
      model_spk = exp_v;
      model_mic_pend = !rdy;
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mix_sat();
    test_deadline();
    test_overrun();
    test_sched_err();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/i2s_stream_sched.md
Name: i2s_stream_sched

Overview:
Per-frame scheduler between the I2S controller sample ports and the vocoder datapath.
- Detects each LRCLK frame boundary.
- Hands the captured mic sample to the datapath over a valid/ready handshake.
- Collects playback samples from two requesters (src0 = vocoder output, src1 = bypass/monitor) under a per-frame mode.
- Commits one speaker sample per frame to the I2S transmit input, by a fixed deadline.

Parameters:
- C_DATA_WIDTH, 24: sample width, signed two's complement.
- C_DEADLINE, 200: CLK_12 cycles after frame event by which collection must finish. Legal range 2..250, which is less than 256 CLK_12 cycles per 48 kHz frame.

Ports:
- CLK_12  in  1  system/audio clock; sole clock.
- resetn  in  1  asynchronous reset, active-high (1 = reset), despite the name.
- LRCLK_I  in  1  LRCLK from the I2S controller, synchronous to CLK_12.
- mic_sample  in  C_DATA_WIDTH  received sample from the I2S controller.
- mic_data  out  C_DATA_WIDTH  captured mic sample to the datapath.
- mic_valid  out  1  mic_data valid.
- mic_ready  in  1  datapath accepts mic_data.
- src0_data / src1_data  in  C_DATA_WIDTH  requester playback samples.
- src0_valid / src1_valid  in  1  requester sample valid.
- src0_ready / src1_ready  out  1  scheduler accepts the requester sample.
- mode  in  2  0 = src0 only, 1 = src1 only, 2 = mix src0+src1, 3 = mute.
- spk_sample  out  C_DATA_WIDTH  committed sample to the I2S transmit input.
- spk_update  out  1  one-cycle pulse when spk_sample changes.
- underrun  out  1  one-cycle pulse: a required source was missing at commit.
- overrun  out  1  one-cycle pulse: mic sample overwritten before it was accepted.
- sched_err  out  1  sticky: frame event arrived while not IDLE.
- clr_err  in  1  synchronous clear of sched_err.

Behaviour:
- Reset: all outputs 0, internal hold register 0, FSM in IDLE, pending flag 0, counter 0.
- Frame event (frame_evt): lrclk_q == 0 and LRCLK_I == 1, where lrclk_q is LRCLK_I registered once. It is a one-cycle internal pulse.

Mic path (independent of the FSM):
- On frame_evt: mic_data <= mic_sample and mic_valid <= 1.
- If mic_valid == 1 and mic_ready == 0 in that same cycle, pulse overrun; the new data overwrites the old.
- The handshake completes when mic_valid && mic_ready; mic_valid <= 0 next cycle unless frame_evt coincides, in which case it stays 1 with the new data and no overrun.

FSM:
- IDLE, on frame_evt or pending:
  - Latch mode into mode_q (a mid-frame mode change is ignored).
  - Clear got0/got1 and the counter; clear pending.
  - Go to COLLECT, or to COMMIT directly if mode_q == 3.
- COLLECT:
  - srcN_ready = required(N, mode_q) && !gotN, asserted combinationally from state registers.
  - srcN_valid && srcN_ready latches the sample and sets gotN; at most one sample per source per frame.
  - The counter increments every cycle.
  - Go to COMMIT when all required gotN are set, or when counter == C_DEADLINE-1.
- COMMIT (one cycle), then back to IDLE:
  - mode 0/1: the selected sample.
  - mode 2: saturating sum. Compute at C_DATA_WIDTH+1 bits and clamp to [-2^(W-1), 2^(W-1)-1].
  - mode 3: 0, no underrun.
  - Any required source missing: output the underrun value (see Optional Feature) and pulse underrun.
  - spk_sample and the hold register update at the end of COMMIT; spk_update pulses during the cycle after COMMIT, aligned with the new spk_sample.
- Latency: frame_evt to spk_update is at most C_DEADLINE+3 cycles. With both sources valid immediately in mode 2 it is exactly 4 cycles.
- frame_evt while state != IDLE:
  - Set sched_err and pending, and force COMMIT next cycle; missing sources count as underrun.
  - IDLE then restarts immediately from pending, so no frame is lost.
- clr_err together with a new error in the same cycle: the set wins.
- Reset asserted mid-frame returns to the reset state immediately; partially collected samples are discarded.

Optional Feature:
- Macro: I2S_SCHED_HOLD_EN.
- Defined: the underrun value is the last committed spk_sample (sample-and-hold concealment).
- Undefined: the underrun value is 0 (silence). The hold register is omitted.

Test Plan:
- mode=0, src0 presents 0x123456 valid 5 cycles after frame_evt -> src0_ready deasserts after accept; spk_sample=0x123456 with a spk_update pulse; underrun=0; src1_ready never asserted.
- mode=2, src0=0x7FFFF0, src1=0x000100, both valid at frame start -> spk_sample=0x7FFFFF (saturated), spk_update exactly 4 cycles after frame_evt.
- mode=1, src1 never valid, C_DEADLINE=200 -> underrun pulse at commit (counter hits 199); spk_sample = previous value with I2S_SCHED_HOLD_EN, 0x000000 without.
- mic_ready held 0 across two frame_evts with mic_sample 0x000AAA then 0x000BBB -> overrun pulse on the second; mic_data=0x000BBB; mic_valid stays 1.
- Shorten the LRCLK period so frame_evt arrives in COLLECT -> sched_err=1, forced commit with underrun, next collection starts with no lost frame; clr_err clears sched_err.
- Assert resetn mid-COLLECT with got0 set -> all outputs 0 immediately; after release the first frame behaves as the first scenario.
